wb_tgt_mem: RTL and testbench

WB_TGT_MEM -- requirements
Module: wb_tgt_mem

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_tgt_mem_pipe.sv | 51 +++++
 rtl/wb_tgt_mem.sv | 105 ++++++++++
 tb/tb_wb_tgt_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: response codes and parameter limits shared by the Wishbone memory target
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACK_RD = 2'd1,
        ACK_WR = 2'd2,
        ERR    = 2'd3
    } rsp_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;
    localparam int MAX_OUT_MIN = 1;

    function automatic logic rsp_is_ack(input rsp_e c);
        return (c == ACK_RD) || (c == ACK_WR);
    endfunction

endpackage

// File: rtl/wb_tgt_mem_pipe.sv
// wb_tgt_mem_pipe: LATENCY-stage response shift register with flush
// Ports: clk_i/async_rst_n_i clock and async active-low reset; flush_i empties every stage
// at the next edge; ld_* loads stage 0; out_* is the last stage (the response now due).
module wb_tgt_mem_pipe
    import wb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DW      = 16,
    parameter int TW      = 1
) (
    input  logic          clk_i,
    input  logic          async_rst_n_i,
    input  logic          flush_i,
    input  logic          ld_i,
    input  rsp_e          ld_code_i,
    input  logic [DW-1:0] ld_dat_i,
    input  logic [TW-1:0] ld_tag_i,
    output rsp_e          out_code_o,
    output logic [DW-1:0] out_dat_o,
    output logic [TW-1:0] out_tag_o
);

    rsp_e          code_q [LATENCY];
    logic [DW-1:0] dat_q  [LATENCY];
    logic [TW-1:0] tag_q  [LATENCY];

    // Only the code needs flushing; data and tags of an EMPTY stage are never observed.
    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                code_q[i] <= EMPTY;
                dat_q[i]  <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            code_q[0] <= (ld_i && !flush_i) ? ld_code_i : EMPTY;
            dat_q[0]  <= ld_dat_i;
            tag_q[0]  <= ld_tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                code_q[i] <= flush_i ? EMPTY : code_q[i-1];
                dat_q[i]  <= dat_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign out_code_o = code_q[LATENCY-1];
    assign out_dat_o  = dat_q[LATENCY-1];
    assign out_tag_o  = tag_q[LATENCY-1];

endmodule

// File: rtl/wb_tgt_mem.sv
// wb_tgt_mem: pipelined Wishbone target backed by a 2^MEM_AW-word lane-writable memory
// Ports: clk_i clock, async_rst_n_i async active-low reset; tgt_* inputs are the Wishbone
// request (lock, tga and write tgd ignored, tgc echoed on tgt_tgd_o); tgt_ack_o/err_o/rty_o
// terminate, tgt_stall_o throttles, tgt_dat_o carries read data in read-ack cycles only.
module wb_tgt_mem
    import wb_pkg::*;
#(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int MEM_AW     = 8,
    parameter int LATENCY    = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic                  clk_i,
    input  logic                  async_rst_n_i,
    input  logic                  tgt_cyc_i,
    input  logic                  tgt_stb_i,
    input  logic                  tgt_we_i,
    input  logic                  tgt_lock_i,
    input  logic [SEL_WIDTH-1:0]  tgt_sel_i,
    input  logic [ADR_WIDTH-1:0]  tgt_adr_i,
    input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
    input  logic [TGA_WIDTH-1:0]  tgt_tga_i,
    input  logic [TGC_WIDTH-1:0]  tgt_tgc_i,
    input  logic [TGWD_WIDTH-1:0] tgt_tgd_i,
    output logic                  tgt_ack_o,
    output logic                  tgt_err_o,
    output logic                  tgt_rty_o,
    output logic                  tgt_stall_o,
    output logic [DAT_WIDTH-1:0]  tgt_dat_o,
    output logic [TGRD_WIDTH-1:0] tgt_tgd_o
);

    localparam int LW = DAT_WIDTH / SEL_WIDTH;
    localparam int CW = $clog2(MAX_OUT + 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX || MAX_OUT < MAX_OUT_MIN ||
        MAX_OUT > LATENCY || DAT_WIDTH % SEL_WIDTH != 0 || MEM_AW > ADR_WIDTH) begin : g_bad_cfg
        $error("wb_tgt_mem: illegal parameter combination");
    end

    logic [DAT_WIDTH-1:0]  mem [2**MEM_AW];
    logic [MEM_AW-1:0]     idx;
    logic                  acc;
    logic                  in_rng;
    logic                  rsp;
    logic [CW-1:0]         cnt_q;
    rsp_e                  ld_code;
    rsp_e                  out_code;
    logic [DAT_WIDTH-1:0]  out_dat;
    logic [TGRD_WIDTH-1:0] out_tag;
    logic                  unused_ok;

    assign unused_ok = ^{tgt_lock_i, tgt_tga_i, tgt_tgd_i};

    assign idx     = tgt_adr_i[MEM_AW-1:0];
    assign in_rng  = ~|(tgt_adr_i >> MEM_AW);
    assign acc     = tgt_cyc_i && tgt_stb_i && !tgt_stall_o;
    assign ld_code = !in_rng ? ERR : tgt_we_i ? ACK_WR : ACK_RD;

    // Stall depends only on registered state; a response leaving this cycle frees a slot.
    assign rsp         = out_code != EMPTY;
    assign tgt_stall_o = (cnt_q == CW'(MAX_OUT)) && !rsp;

    // Reset gating keeps a request presented during reset from touching the array.
    always_ff @(posedge clk_i)
        if (acc && in_rng && tgt_we_i && async_rst_n_i)
            for (int l = 0; l < SEL_WIDTH; l++)
                if (tgt_sel_i[l]) mem[idx][l*LW +: LW] <= tgt_dat_i[l*LW +: LW];

    always_ff @(posedge clk_i or negedge async_rst_n_i)
        if (!async_rst_n_i) cnt_q <= '0;
        else cnt_q <= !tgt_cyc_i ? '0 : cnt_q + CW'(acc) - CW'(rsp);

    // The read word is captured at acceptance, so a same-edge write is not seen.
    wb_tgt_mem_pipe #(
        .LATENCY (LATENCY),
        .DW      (DAT_WIDTH),
        .TW      (TGRD_WIDTH)
    ) u_pipe (
        .clk_i         (clk_i),
        .async_rst_n_i (async_rst_n_i),
        .flush_i       (!tgt_cyc_i),
        .ld_i          (acc),
        .ld_code_i     (ld_code),
        .ld_dat_i      (mem[idx]),
        .ld_tag_i      (TGRD_WIDTH'(tgt_tgc_i)),
        .out_code_o    (out_code),
        .out_dat_o     (out_dat),
        .out_tag_o     (out_tag)
    );

    // Dropping cyc suppresses whatever response is due in the same cycle.
    assign tgt_ack_o = tgt_cyc_i && rsp_is_ack(out_code);
    assign tgt_err_o = tgt_cyc_i && (out_code == ERR);
    assign tgt_rty_o = 1'b0;
    assign tgt_dat_o = (tgt_cyc_i && out_code == ACK_RD) ? out_dat : '0;
    assign tgt_tgd_o = (tgt_cyc_i && rsp) ? out_tag : '0;

endmodule

// File: tb/tb_wb_tgt_mem.sv
// tb_wb_tgt_mem: directed self-checking bench for wb_tgt_mem (default and MAX_OUT=1 instances)
module tb_wb_tgt_mem;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] adr = '0, dat = '0;
    logic        tga = 1'b0, tgc = 1'b0, tgdi = 1'b0;
    logic        ack, err, rty, stall, tgdo;
    logic [15:0] dato;
    logic        ack1, err1, rty1, stall1, tgdo1;
    logic [15:0] dato1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_i = ~clk_i;

    wb_tgt_mem u_dut (
        .clk_i(clk_i), .async_rst_n_i(rst_n), .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we),
        .tgt_lock_i(lock), .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat), .tgt_tga_i(tga),
        .tgt_tgc_i(tgc), .tgt_tgd_i(tgdi), .tgt_ack_o(ack), .tgt_err_o(err), .tgt_rty_o(rty),
        .tgt_stall_o(stall), .tgt_dat_o(dato), .tgt_tgd_o(tgdo)
    );

    wb_tgt_mem #(.MAX_OUT(1)) u_dut1 (
        .clk_i(clk_i), .async_rst_n_i(rst_n), .tgt_cyc_i(cyc), .tgt_stb_i(stb), .tgt_we_i(we),
        .tgt_lock_i(lock), .tgt_sel_i(sel), .tgt_adr_i(adr), .tgt_dat_i(dat), .tgt_tga_i(tga),
        .tgt_tgc_i(tgc), .tgt_tgd_i(tgdi), .tgt_ack_o(ack1), .tgt_err_o(err1), .tgt_rty_o(rty1),
        .tgt_stall_o(stall1), .tgt_dat_o(dato1), .tgt_tgd_o(tgdo1)
    );

    always begin
        @(negedge clk_i);
        #3;
        checks++;
        if ((ack && err) || rty || (ack1 && err1) || rty1) begin
            failures++;
            $display("FAIL mon_onehot ack=%b err=%b rty=%b ack1=%b err1=%b rty1=%b", ack, err, rty, ack1, err1, rty1);
        end
    end

    task automatic bus(input logic c, input logic s, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] sl, input logic tg);
        @(negedge clk_i);
        cyc = c; stb = s; we = w; adr = a; dat = d; sel = sl; tgc = tg;
        #1;
    endtask

    task automatic idle;
        bus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cyc = 1'b1; stb = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if ({ack, err, rty, stall, dato, tgdo} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b err=%b rty=%b stall=%b dat=%h tgd=%b exp all 0", ack, err, rty, stall, dato, tgdo);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0005; dat = 16'hBEEF; sel = 2'b11; tgc = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL first_accept_stall got=%b exp=0", stall); end
        idle;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wr_early ack=%b err=%b exp 0/0", ack, err); end
        bus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00, 1'b0);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wr_ack ack=%b err=%b exp 1/0", ack, err); end
        checks++;
        if (dato !== 16'h0) begin failures++; $display("FAIL wr_ack_dat got=%h exp=0000", dato); end
        checks++;
        if (tgdo !== 1'b1) begin failures++; $display("FAIL wr_tag got=%b exp=1", tgdo); end
        idle;
        checks++;
        if (ack !== 1'b0 || tgdo !== 1'b0) begin failures++; $display("FAIL rd_early ack=%b tgd=%b exp 0/0", ack, tgdo); end
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'hBEEF) begin failures++; $display("FAIL rd_beef ack=%b dat=%h exp 1/BEEF", ack, dato); end
        checks++;
        if (tgdo !== 1'b0) begin failures++; $display("FAIL rd_tag got=%b exp=0", tgdo); end
        idle;
        checks++;
        if (ack !== 1'b0 || dato !== 16'h0) begin failures++; $display("FAIL rd_one_cycle ack=%b dat=%h exp 0/0000", ack, dato); end
    endtask

    task automatic test_partial;
        bus(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1234, 2'b01, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL part_wr_ack got=%b exp=1", ack); end
        bus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'hBE34) begin failures++; $display("FAIL part_rd ack=%b dat=%h exp 1/BE34", ack, dato); end
    endtask

    task automatic test_err;
        bus(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, 1'b1);
        idle;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err); end
        idle;
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL oor_rd err=%b ack=%b exp 1/0", err, ack); end
        checks++;
        if (dato !== 16'h0 || tgdo !== 1'b1) begin failures++; $display("FAIL oor_rd_dat dat=%h tgd=%b exp 0000/1", dato, tgdo); end
        bus(1'b1, 1'b1, 1'b1, 16'h0105, 16'h0000, 2'b11, 1'b0);
        idle;
        idle;
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL oor_wr err=%b ack=%b exp 1/0", err, ack); end
        bus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'hBE34) begin failures++; $display("FAIL oor_untouched ack=%b dat=%h exp 1/BE34", ack, dato); end
        bus(1'b1, 1'b1, 1'b1, 16'h00FF, 16'hA5A5, 2'b11, 1'b0);
        idle;
        idle;
        bus(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0, 2'b00, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1 || err !== 1'b0 || dato !== 16'hA5A5) begin failures++; $display("FAIL top_word ack=%b err=%b dat=%h exp 1/0/A5A5", ack, err, dato); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b1, 1'b1, 16'(32 + i), 16'(16'h1111 * (i + 1)), 2'b11, 1'b0);
            idle;
            idle;
        end
        bus(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 1'b0);
        checks++;
        if (stall !== 1'b0 || stall1 !== 1'b0) begin failures++; $display("FAIL b2b_c0 stall=%b stall1=%b exp 0/0", stall, stall1); end
        bus(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0, 2'b00, 1'b0);
        checks++;
        if (stall !== 1'b0 || ack !== 1'b0) begin failures++; $display("FAIL b2b_c1 stall=%b ack=%b exp 0/0", stall, ack); end
        checks++;
        if (stall1 !== 1'b1) begin failures++; $display("FAIL b2b_c1_stall1 got=%b exp=1", stall1); end
        bus(1'b1, 1'b1, 1'b0, 16'h0022, 16'h0, 2'b00, 1'b0);
        checks++;
        if (ack !== 1'b1 || dato !== 16'h1111 || stall !== 1'b0) begin failures++; $display("FAIL b2b_c2 ack=%b dat=%h stall=%b exp 1/1111/0", ack, dato, stall); end
        checks++;
        if (ack1 !== 1'b1 || dato1 !== 16'h1111 || stall1 !== 1'b0) begin failures++; $display("FAIL b2b_c2_dut1 ack=%b dat=%h stall=%b exp 1/1111/0", ack1, dato1, stall1); end
        bus(1'b1, 1'b1, 1'b0, 16'h0023, 16'h0, 2'b00, 1'b0);
        checks++;
        if (ack !== 1'b1 || dato !== 16'h2222 || stall !== 1'b0) begin failures++; $display("FAIL b2b_c3 ack=%b dat=%h stall=%b exp 1/2222/0", ack, dato, stall); end
        checks++;
        if (ack1 !== 1'b0 || stall1 !== 1'b1) begin failures++; $display("FAIL b2b_c3_dut1 ack=%b stall=%b exp 0/1", ack1, stall1); end
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'h3333) begin failures++; $display("FAIL b2b_c4 ack=%b dat=%h exp 1/3333", ack, dato); end
        checks++;
        if (ack1 !== 1'b1 || dato1 !== 16'h3333) begin failures++; $display("FAIL b2b_c4_dut1 ack=%b dat=%h exp 1/3333", ack1, dato1); end
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'h4444) begin failures++; $display("FAIL b2b_c5 ack=%b dat=%h exp 1/4444", ack, dato); end
        checks++;
        if (ack1 !== 1'b0) begin failures++; $display("FAIL b2b_c5_dut1 ack=%b exp 0", ack1); end
        idle;
        checks++;
        if (ack !== 1'b0 || stall !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL b2b_drain ack=%b stall=%b ack1=%b exp 0/0/0", ack, stall, ack1); end
    endtask

    task automatic test_abort;
        bus(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, 1'b0);
        bus(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0, 2'b00, 1'b0);
        bus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        checks++;
        if (ack !== 1'b0 || err !== 1'b0 || dato !== 16'h0) begin failures++; $display("FAIL abort_c2 ack=%b err=%b dat=%h exp 0/0/0000", ack, err, dato); end
        idle;
        checks++;
        if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL abort_c3 ack=%b err=%b exp 0/0", ack, err); end
        checks++;
        if (u_dut.cnt_q !== 2'd0 || stall !== 1'b0 || stall1 !== 1'b0) begin failures++; $display("FAIL abort_cnt cnt=%0d stall=%b stall1=%b exp 0/0/0", u_dut.cnt_q, stall, stall1); end
        idle;
        checks++;
        if (ack !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL abort_c4 ack=%b ack1=%b exp 0/0", ack, ack1); end
        bus(1'b1, 1'b1, 1'b0, 16'h0022, 16'h0, 2'b00, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'h3333 || ack1 !== 1'b1) begin failures++; $display("FAIL abort_recover ack=%b dat=%h ack1=%b exp 1/3333/1", ack, dato, ack1); end
    endtask

    task automatic test_reset_mid;
        bus(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0, 2'b00, 1'b1);
        bus(1'b1, 1'b1, 1'b0, 16'h0022, 16'h0, 2'b00, 1'b1);
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'h2222 || tgdo !== 1'b1) begin failures++; $display("FAIL rstmid_pre ack=%b dat=%h tgd=%b exp 1/2222/1", ack, dato, tgdo); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, err, rty, stall, dato, tgdo} !== 21'd0) begin
            failures++;
            $display("FAIL rstmid_async ack=%b err=%b rty=%b stall=%b dat=%h tgd=%b exp all 0", ack, err, rty, stall, dato, tgdo);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle;
            checks++;
            if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rstmid_post%0d ack=%b err=%b exp 0/0", i, ack, err); end
        end
        bus(1'b1, 1'b1, 1'b0, 16'h0023, 16'h0, 2'b00, 1'b0);
        idle;
        idle;
        checks++;
        if (ack !== 1'b1 || dato !== 16'h4444) begin failures++; $display("FAIL rstmid_recover ack=%b dat=%h exp 1/4444", ack, dato); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_partial;
        test_err;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        idle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
